// File: rtl/param_sync_fifo_pkg.sv
// rtl/param_sync_fifo_pkg.sv - shared constants and types for param_sync_fifo
package param_sync_fifo_pkg;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fwft_state_e;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int depth_log);
    return depth_log + 1;
  endfunction

endpackage

// File: rtl/model_dual_ram.sv
// rtl/model_dual_ram.sv - simple dual-port RAM, one write port, registered read port
module model_dual_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock FIFO with standard or FWFT read mode
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 8,
  parameter int FWFT      = FWFT_STD,
  parameter int AF_LEVEL  = (1 << DEPTH_LOG) - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               full,
  output logic               almost_full,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               empty,
  output logic               almost_empty,
  output logic [DEPTH_LOG:0] data_count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);

  localparam int PTR_W = ptr_width(DEPTH_LOG);
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_count;
  logic [WIDTH-1:0] out_data_q, out_data_d, ram_rdata;
  logic             stage_q, stage_d, out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             wr_acc, pop, ram_rd, load;
  fwft_state_e      state_q, state_d;

  assign ram_count = wr_ptr_q - rd_ptr_q;

  // In FWFT mode the staged RAM word and the output register still belong to the queue.
  always_comb begin
    if (FWFT == FWFT_ON) data_count = ram_count + PTR_W'(stage_q) + PTR_W'(out_valid_q);
    else                 data_count = ram_count;
  end

  assign full         = (data_count == PTR_W'(DEPTH));
  assign empty        = (FWFT == FWFT_ON) ? !out_valid_q : (ram_count == '0);
  assign almost_full  = (int'(data_count) >= AF_LEVEL);
  assign almost_empty = (int'(data_count) <= AE_LEVEL);
  assign wr_acc       = wr_en && !full;
  assign pop          = rd_en && !empty;

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    out_valid_d = out_valid_q;
    ram_rd      = 1'b0;
    load        = 1'b0;
    if (FWFT == FWFT_ON) begin
      // stage_q marks a word sitting in the RAM read register; refill it as it drains
      load    = stage_q && ((state_q != ST_VALID) || pop);
      ram_rd  = (ram_count != '0) && (!stage_q || load);
      stage_d = ram_rd || (stage_q && !load);
      case (state_q)
        ST_EMPTY: if (ram_rd) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_VALID;
        ST_VALID: if (pop && !stage_q) state_d = ram_rd ? ST_FETCH : ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
      out_valid_d = (state_d == ST_VALID);
    end else begin
      ram_rd      = pop;
      load        = stage_q;
      stage_d     = ram_rd;
      out_valid_d = stage_q;
    end
  end

  assign wr_ptr_d   = wr_ptr_q + PTR_W'(wr_acc);
  assign rd_ptr_d   = rd_ptr_q + PTR_W'(ram_rd);
  assign out_data_d = load ? ram_rdata : out_data_q;

  // Setting an error flag takes priority over a same-cycle clear.
  always_comb begin
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wr_en && full) overflow_d = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      stage_q     <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_EMPTY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  assign rd_data   = out_data_q;
  assign rd_valid  = out_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  model_dual_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[DEPTH_LOG-1:0]),
    .wdata (wr_data),
    .re    (ram_rd),
    .raddr (rd_ptr_q[DEPTH_LOG-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench for standard and FWFT param_sync_fifo
module tb_param_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Standard-mode instance: depth 8, AF=6, AE=1
  logic       s_rst, s_wr_en, s_rd_en, s_clr_err;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_full, s_almost_full, s_rd_valid, s_empty, s_almost_empty, s_overflow, s_underflow;
  logic [3:0] s_data_count;

  param_sync_fifo #(.WIDTH(8), .DEPTH_LOG(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full),
    .almost_full(s_almost_full), .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .empty(s_empty), .almost_empty(s_almost_empty), .data_count(s_data_count),
    .overflow(s_overflow), .underflow(s_underflow), .clr_err(s_clr_err)
  );

  // FWFT instance: depth 16, default thresholds
  logic       f_rst, f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_full, f_almost_full, f_rd_valid, f_empty, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_data_count;

  param_sync_fifo #(.WIDTH(8), .DEPTH_LOG(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full),
    .almost_full(f_almost_full), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .empty(f_empty), .almost_empty(f_almost_empty), .data_count(f_data_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  logic [7:0] s_q[$];
  logic [7:0] f_q[$];
  int s_cnt = 0;
  int s_rd_exp = 0;
  int s_rd_seen = 0;

  always @(negedge clk) begin
    if (s_rd_valid === 1'b1) begin
      s_rd_seen++;
      if (s_q.size() == 0) check("s_rd_unexpected", 32'(s_rd_valid), 32'd0);
      else                 check("s_rd_data", 32'(s_rd_data), 32'(s_q.pop_front()));
    end
  end

  // Drive one cycle on the standard FIFO and advance the reference model.
  task automatic s_drive(input logic wr, input logic [7:0] d, input logic rd);
    bit wok, rok;
    s_wr_en = wr; s_wr_data = d; s_rd_en = rd;
    wok = wr && (s_cnt < 8);
    rok = rd && (s_cnt > 0);
    if (wok) s_q.push_back(d);
    if (rok) s_rd_exp++;
    s_cnt = s_cnt + int'(wok) - int'(rok);
    @(negedge clk);
    s_wr_en = 1'b0; s_rd_en = 1'b0;
  endtask

  task automatic s_check_flags();
    check("s_count", 32'(s_data_count), 32'(s_cnt));
    check("s_full", 32'(s_full), 32'(s_cnt == 8));
    check("s_empty", 32'(s_empty), 32'(s_cnt == 0));
    check("s_almost_full", 32'(s_almost_full), 32'(s_cnt >= 6));
    check("s_almost_empty", 32'(s_almost_empty), 32'(s_cnt <= 1));
  endtask

  task automatic s_idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr_err = 1'b0; s_wr_data = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = '0;
    repeat (2) @(negedge clk);
    s_rst = 1'b0; f_rst = 1'b0;
    @(negedge clk);

    s_check_flags();
    check("s_rst_rd_valid", 32'(s_rd_valid), 32'd0);
    check("s_rst_rd_data", 32'(s_rd_data), 32'd0);
    check("s_rst_overflow", 32'(s_overflow), 32'd0);
    check("s_rst_underflow", 32'(s_underflow), 32'd0);
    check("f_rst_empty", 32'(f_empty), 32'd1);
    check("f_rst_rd_valid", 32'(f_rd_valid), 32'd0);
    check("f_rst_almost_full", 32'(f_almost_full), 32'd0);

    // Fill 0x11..0x18 then drain, watching every threshold on the way
    for (int i = 0; i < 8; i++) begin
      s_drive(1'b1, 8'(8'h11 + i), 1'b0);
      s_check_flags();
    end
    for (int i = 0; i < 8; i++) begin
      s_drive(1'b0, 8'h00, 1'b1);
      s_check_flags();
    end
    s_idle(3);

    // Full: simultaneous read and write, write dropped
    for (int i = 0; i < 8; i++) s_drive(1'b1, 8'(8'h40 + i), 1'b0);
    s_drive(1'b1, 8'hAA, 1'b1);
    check("s_overflow_set", 32'(s_overflow), 32'd1);
    s_check_flags();
    s_clr_err = 1'b1; @(negedge clk); s_clr_err = 1'b0;
    check("s_overflow_clr", 32'(s_overflow), 32'd0);
    for (int i = 0; i < 7; i++) s_drive(1'b0, 8'h00, 1'b1);
    s_idle(3);
    s_check_flags();

    // Empty: simultaneous read and write, read dropped; check read latency
    s_drive(1'b1, 8'h5A, 1'b1);
    check("s_underflow_set", 32'(s_underflow), 32'd1);
    s_check_flags();
    s_drive(1'b0, 8'h00, 1'b1);
    check("s_rd_latency0", 32'(s_rd_valid), 32'd0);
    @(negedge clk);
    check("s_rd_latency1", 32'(s_rd_valid), 32'd1);
    @(negedge clk);
    check("s_rd_pulse", 32'(s_rd_valid), 32'd0);
    check("s_rd_hold", 32'(s_rd_data), 32'h5A);
    s_clr_err = 1'b1; @(negedge clk); s_clr_err = 1'b0;
    check("s_underflow_clr", 32'(s_underflow), 32'd0);

    // Pointer wrap: three fill/drain rounds with ramp data
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) s_drive(1'b1, 8'(8'h20 + c * 8 + i), 1'b0);
      s_check_flags();
      for (int i = 0; i < 8; i++) s_drive(1'b0, 8'h00, 1'b1);
      s_check_flags();
    end
    s_idle(3);

    // Async reset mid-stream at count 5 with a read in flight
    s_drive(1'b0, 8'h00, 1'b1);
    check("s_underflow_pre", 32'(s_underflow), 32'd1);
    for (int i = 0; i < 6; i++) s_drive(1'b1, 8'(8'h60 + i), 1'b0);
    s_drive(1'b0, 8'h00, 1'b1);
    s_check_flags();
    #2 s_rst = 1'b1;
    #1;
    s_q.delete(); s_cnt = 0; s_rd_exp = s_rd_seen;
    s_check_flags();
    check("s_arst_rd_valid", 32'(s_rd_valid), 32'd0);
    check("s_arst_rd_data", 32'(s_rd_data), 32'd0);
    check("s_arst_underflow", 32'(s_underflow), 32'd0);
    check("s_arst_overflow", 32'(s_overflow), 32'd0);
    @(negedge clk); @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
    check("s_post_rst_rd_valid", 32'(s_rd_valid), 32'd0);
    s_drive(1'b1, 8'h77, 1'b0);
    s_drive(1'b0, 8'h00, 1'b1);
    s_idle(3);
    s_check_flags();
    check("s_reads_seen", 32'(s_rd_seen), 32'(s_rd_exp));
    check("s_sb_drained", 32'(s_q.size()), 32'd0);

    // FWFT: single word appears two edges after the write
    f_wr_en = 1'b1; f_wr_data = 8'h3C;
    @(negedge clk);
    f_wr_en = 1'b0;
    check("f_k0_valid", 32'(f_rd_valid), 32'd0);
    check("f_k0_count", 32'(f_data_count), 32'd1);
    @(negedge clk);
    check("f_k1_valid", 32'(f_rd_valid), 32'd0);
    @(negedge clk);
    check("f_k2_valid", 32'(f_rd_valid), 32'd1);
    check("f_k2_data", 32'(f_rd_data), 32'h3C);
    check("f_k2_empty", 32'(f_empty), 32'd0);
    f_rd_en = 1'b1;
    @(negedge clk);
    f_rd_en = 1'b0;
    check("f_pop_empty", 32'(f_empty), 32'd1);
    check("f_pop_count", 32'(f_data_count), 32'd0);

    // FWFT streaming: fill 16, then pop one per cycle with no bubble
    for (int i = 0; i < 16; i++) begin
      f_wr_en = 1'b1; f_wr_data = 8'(8'hA0 + i);
      f_q.push_back(8'(8'hA0 + i));
      @(negedge clk);
    end
    f_wr_en = 1'b0;
    check("f_full", 32'(f_full), 32'd1);
    check("f_full_count", 32'(f_data_count), 32'd16);
    @(negedge clk); @(negedge clk);
    check("f_full_after_prefetch", 32'(f_data_count), 32'd16);
    f_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("f_nobubble", 32'(f_rd_valid), 32'd1);
      if (f_q.size() > 0) check("f_stream_data", 32'(f_rd_data), 32'(f_q.pop_front()));
      @(negedge clk);
    end
    f_rd_en = 1'b0;
    check("f_drained_empty", 32'(f_empty), 32'd1);
    check("f_drained_count", 32'(f_data_count), 32'd0);
    check("f_no_underflow", 32'(f_underflow), 32'd0);
    check("f_no_overflow", 32'(f_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
